// File: rtl/acc_dp16.sv
// acc_dp16 -- datapath companion to the 16-step accumulation controller.
// Accumulates one signed x_in*w_in product per step index 0..15. The full
// window sum is published on acc_out with a one-cycle out_valid strobe. Any
// illegal step transition sets the sticky seq_err flag.
// Optional build macro: ACC_DP16_RELU_EN. When it is defined, the published
// result is clamped at zero (ReLU). The internal accumulator is unaffected.
module acc_dp16 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20  // must be >= 2*DATA_W+4 so 16 full products fit
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               state,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     out_valid,
  output logic                     seq_err
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [3:0] LAST_STEP = 4'd15;

  // Classification of the sampled step against the window in progress.
  typedef enum logic [1:0] {
    STEP_START,      // state==0: begin or restart a window
    STEP_ADVANCE,    // armed and state==prev_state+1
    STEP_VIOLATION,  // armed and anything else
    STEP_IGNORE      // not armed and state!=0
  } step_kind_e;

  logic signed [ACC_W-1:0]  acc;
  logic                     armed;
  logic [3:0]               prev_state;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [ACC_W-1:0]  result;
  logic [3:0]               expected_step;
  step_kind_e               step_kind;
  logic                     window_done;

  // Full-precision signed product, sign-extended to the accumulator width.
  assign prod     = x_in * w_in;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign sum_next = acc + prod_ext;

  // After step 15 the wrap to 0 is covered by the restart case, so the
  // 4-bit wrap of this increment never causes a false match.
  assign expected_step = prev_state + 4'd1;

`ifdef ACC_DP16_RELU_EN
  // Negative window sums are published as zero.
  assign result = sum_next[ACC_W-1] ? '0 : sum_next;
`else
  assign result = sum_next;
`endif

  // Decide which rule applies to the step sampled at the next edge.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned, which would infer a latch.
    step_kind = STEP_IGNORE;
    if (state == 4'd0) begin
      step_kind = STEP_START;
    end else if (armed) begin
      if (state == expected_step) step_kind = STEP_ADVANCE;
      else                        step_kind = STEP_VIOLATION;
    end
  end

  assign window_done = (step_kind == STEP_ADVANCE) && (state == LAST_STEP);

  // Window tracking: running sum, armed flag and previous step index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      armed      <= 1'b0;
      prev_state <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      prev_state <= state;
      case (step_kind)
        STEP_START: begin
          acc   <= prod_ext;
          armed <= 1'b1;
        end
        STEP_ADVANCE: begin
          acc <= sum_next;
        end
        STEP_VIOLATION: begin
          armed <= 1'b0;
        end
        default: begin
          // Not in a window: hold everything until a state==0 sample.
        end
      endcase
    end
  end

  // Result publication, completion strobe and sticky sequence error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out   <= '0;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      out_valid <= window_done;
      if (window_done) begin
        acc_out <= result;
      end
      if (step_kind == STEP_VIOLATION) begin
        seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_dp16.sv
// Self-checking bench for acc_dp16. Directed scenarios compare against
// hand-derived constants. A randomized run compares every cycle against a
// window-level reference model that keeps the products of the current window
// in a queue and sums them when a legal window completes.
module tb_acc_dp16;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [3:0]               state = 4'd0;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [DATA_W-1:0] w_in = '0;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     out_valid;
  logic                     seq_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  acc_dp16 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .x_in      (x_in),
    .w_in      (w_in),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .seq_err   (seq_err)
  );

  // ---------------- reference model ----------------
  longint                  m_terms[$];
  bit                      m_in_window;
  int                      m_last;
  bit                      m_valid;
  bit                      m_err;
  logic signed [ACC_W-1:0] m_acc_out;

  task automatic model_reset();
    m_terms.delete();
    m_in_window = 1'b0;
    m_last      = 0;
    m_valid     = 1'b0;
    m_err       = 1'b0;
    m_acc_out   = '0;
  endtask

  task automatic model_step(input int s, input longint p);
    longint total;
    m_valid = 1'b0;
    if (s == 0) begin
      m_terms.delete();
      m_terms.push_back(p);
      m_in_window = 1'b1;
    end else if (m_in_window && s == m_last + 1) begin
      m_terms.push_back(p);
      if (s == 15) begin
        total = 0;
        foreach (m_terms[i]) total += m_terms[i];
`ifdef ACC_DP16_RELU_EN
        if (total < 0) total = 0;
`endif
        m_acc_out = total[ACC_W-1:0];
        m_valid   = 1'b1;
      end
    end else if (m_in_window) begin
      m_err       = 1'b1;
      m_in_window = 1'b0;
    end
    m_last = s;
  endtask

  // ---------------- stimulus helpers ----------------
  int wx[16];
  int ww[16];

  // Drive one step on the falling edge and let the DUT sample it. Returns on
  // the following falling edge, where outputs are stable for comparison.
  task automatic step(input int s, input int x, input int w);
    state = 4'(s);
    x_in  = DATA_W'(x);
    w_in  = DATA_W'(w);
    model_step(s, longint'(x_in) * longint'(w_in));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic assert_reset(input int s_hold);
    rst   = 1'b1;
    state = 4'(s_hold);
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a complete 0..15 window from wx/ww.
  task automatic run_window(output int early, output logic vlast,
                            output logic signed [ACC_W-1:0] alast);
    early = 0;
    for (int i = 0; i < 16; i++) begin
      step(i, wx[i], ww[i]);
      if (i < 15 && out_valid) early++;
    end
    vlast = out_valid;
    alast = acc_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++; if (acc_out !== '0) begin n_bad++; $display("FAIL reset_acc_out: got %0d expected 0", acc_out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    release_reset();
  endtask

  task automatic test_ones();
    int early; logic vlast; logic signed [ACC_W-1:0] alast;
    for (int i = 0; i < 16; i++) begin wx[i] = 1; ww[i] = 1; end
    run_window(early, vlast, alast);
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL ones_early_strobe: got %0d expected 0", early); end
    n_cmp++; if (vlast !== 1'b1) begin n_bad++; $display("FAIL ones_valid: got %b expected 1", vlast); end
    n_cmp++; if (alast !== ACC_W'(16)) begin n_bad++; $display("FAIL ones_acc_out: got %0d expected 16", alast); end
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL ones_seq_err: got %b expected 0", seq_err); end
    step(0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ones_valid_drop: got %b expected 0", out_valid); end
    n_cmp++; if (acc_out !== ACC_W'(16)) begin n_bad++; $display("FAIL ones_acc_hold: got %0d expected 16", acc_out); end
  endtask

  task automatic test_back_to_back();
    int early; logic vlast; logic signed [ACC_W-1:0] alast;
    logic signed [ACC_W-1:0] exp2;
`ifdef ACC_DP16_RELU_EN
    exp2 = '0;
`else
    exp2 = ACC_W'(-260096);
`endif
    for (int i = 0; i < 16; i++) begin wx[i] = -128; ww[i] = -128; end
    run_window(early, vlast, alast);
    n_cmp++; if (vlast !== 1'b1) begin n_bad++; $display("FAIL b2b_valid1: got %b expected 1", vlast); end
    n_cmp++; if (alast !== ACC_W'(262144)) begin n_bad++; $display("FAIL b2b_acc1: got %0d expected 262144", alast); end
    for (int i = 0; i < 16; i++) begin wx[i] = -128; ww[i] = 127; end
    run_window(early, vlast, alast);
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL b2b_spacing: got %0d early strobes expected 0", early); end
    n_cmp++; if (vlast !== 1'b1) begin n_bad++; $display("FAIL b2b_valid2: got %b expected 1", vlast); end
    n_cmp++; if (alast !== exp2) begin n_bad++; $display("FAIL b2b_acc2: got %0d expected %0d", alast, exp2); end
  endtask

  task automatic test_alternating();
    int early; logic vlast; logic signed [ACC_W-1:0] alast;
    for (int i = 0; i < 16; i++) begin wx[i] = (i % 2 == 0) ? 3 : -3; ww[i] = 5; end
    run_window(early, vlast, alast);
    n_cmp++; if (vlast !== 1'b1 || alast !== '0) begin n_bad++; $display("FAIL alt_zero: got valid=%b acc=%0d expected valid=1 acc=0", vlast, alast); end
    for (int i = 0; i < 16; i++) begin wx[i] = i; ww[i] = i; end
    run_window(early, vlast, alast);
    n_cmp++; if (vlast !== 1'b1 || alast !== ACC_W'(1240)) begin n_bad++; $display("FAIL squares: got valid=%b acc=%0d expected valid=1 acc=1240", vlast, alast); end
  endtask

  task automatic test_mid_reset();
    int early; logic vlast; logic signed [ACC_W-1:0] alast;
    int strobes;
    strobes = 0;
    for (int i = 0; i <= 7; i++) begin
      step(i, 2, 2);
      if (out_valid) strobes++;
    end
    assert_reset(7);
    n_cmp++; if (acc_out !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_async_clear: got acc=%0d valid=%b expected 0/0", acc_out, out_valid); end
    release_reset();
    for (int i = 0; i < 16; i++) begin wx[i] = 2; ww[i] = 2; end
    run_window(early, vlast, alast);
    n_cmp++; if (strobes + early !== 0) begin n_bad++; $display("FAIL midrst_stray_strobe: got %0d expected 0", strobes + early); end
    n_cmp++; if (vlast !== 1'b1 || alast !== ACC_W'(64)) begin n_bad++; $display("FAIL midrst_acc: got valid=%b acc=%0d expected valid=1 acc=64", vlast, alast); end
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL midrst_seq_err: got %b expected 0", seq_err); end
  endtask

  task automatic test_release_mid();
    int early; logic vlast; logic signed [ACC_W-1:0] alast;
    int strobes; int errs;
    strobes = 0; errs = 0;
    assert_reset(9);
    release_reset();
    for (int i = 9; i < 16; i++) begin
      step(i, 7, 9);
      if (out_valid) strobes++;
      if (seq_err) errs++;
    end
    n_cmp++; if (strobes !== 0 || errs !== 0) begin n_bad++; $display("FAIL relmid_partial: got strobes=%0d errs=%0d expected 0/0", strobes, errs); end
    for (int i = 0; i < 16; i++) begin wx[i] = 1; ww[i] = 3; end
    run_window(early, vlast, alast);
    n_cmp++; if (vlast !== 1'b1 || alast !== ACC_W'(48) || seq_err !== 1'b0) begin n_bad++; $display("FAIL relmid_window: got valid=%b acc=%0d err=%b expected 1/48/0", vlast, alast, seq_err); end
  endtask

  task automatic test_skip();
    int early; logic vlast; logic signed [ACC_W-1:0] alast;
    logic signed [ACC_W-1:0] exp_neg;
    int strobes;
`ifdef ACC_DP16_RELU_EN
    exp_neg = '0;
`else
    exp_neg = ACC_W'(-224);
`endif
    strobes = 0;
    step(0, 1, 1); step(1, 1, 1); step(2, 1, 1);
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL skip_err_before: got %b expected 0", seq_err); end
    step(4, 1, 1);
    n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL skip_err_set: got %b expected 1", seq_err); end
    for (int i = 5; i < 16; i++) begin
      step(i, 1, 1);
      if (out_valid) strobes++;
    end
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL skip_no_strobe: got %0d expected 0", strobes); end
    for (int i = 0; i < 16; i++) begin wx[i] = -2; ww[i] = 7; end
    run_window(early, vlast, alast);
    n_cmp++; if (vlast !== 1'b1 || alast !== exp_neg) begin n_bad++; $display("FAIL skip_recover: got valid=%b acc=%0d expected 1/%0d", vlast, alast, exp_neg); end
    n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL skip_err_sticky: got %b expected 1", seq_err); end
    assert_reset(0);
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL skip_err_clear: got %b expected 0", seq_err); end
    release_reset();
  endtask

  task automatic test_random();
    int s; int gen_prev; int bad_here;
    gen_prev = 15;
    bad_here = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        assert_reset(int'($urandom_range(0, 15)));
        release_reset();
      end
      if ($urandom_range(0, 24) == 0) s = int'($urandom_range(0, 15));
      else                            s = (gen_prev + 1) % 16;
      gen_prev = s;
      step(s, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      n_cmp++;
      if (out_valid !== m_valid || seq_err !== m_err || acc_out !== m_acc_out) begin
        n_bad++;
        if (bad_here < 10)
          $display("FAIL random_cycle%0d: got valid=%b err=%b acc=%0d expected valid=%b err=%b acc=%0d",
                   n, out_valid, seq_err, acc_out, m_valid, m_err, m_acc_out);
        bad_here++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_back_to_back();
    test_alternating();
    test_mid_reset();
    test_release_mid();
    test_skip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_dp16.md
Name: acc_dp16

Overview:
- Datapath companion to the 16-step accumulation controller.
- Consumes the controller's 4-bit step index and accumulates 16 signed input×weight products, one per step.
- Emits one neuron pre-activation sum per 16-step window, with a single-cycle valid strobe.
- Checks that the step index advances legally and flags any sequence violation.

Parameters:
- DATA_W, 8, width of signed input and weight operands
- ACC_W, 20, width of signed accumulator and result; must be ≥ 2*DATA_W+4

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous reset, active-high
- state  input  4  step index from controller; 0 starts a window, 15 ends it
- x_in  input  DATA_W  signed activation for the current step
- w_in  input  DATA_W  signed weight for the current step
- acc_out  output  ACC_W  signed result of the last completed window; held between windows
- out_valid  output  1  one-cycle strobe: acc_out was updated on this edge
- seq_err  output  1  sticky flag: illegal step transition seen since reset

Behaviour:
- Reset (asynchronous, rst=1):
  - acc=0, acc_out=0, out_valid=0, seq_err=0, armed=0, prev_state=0.
  - Reset may be asserted at any time, including mid-window; the partial sum is discarded.
- Product: prod = sign-extended x_in×w_in, full 2*DATA_W bits, sign-extended to ACC_W. No rounding.
- Accumulator arithmetic: ACC_W-bit two's complement, wrap-around on overflow. The default width cannot overflow for 16 terms.
- Internal flag armed: set only by a state==0 sample; window in progress.
- At each rising edge, sample state, x_in, w_in and apply the first matching case:
  - state==0: acc<=prod; armed<=1. Always legal; restarts any window in progress without error.
  - armed=1 and state==prev_state+1: acc<=acc+prod.
    - If state==15, also acc_out<=acc+prod and out_valid<=1.
  - armed=1 and state≠prev_state+1 (skip, repeat, backwards): seq_err<=1, armed<=0.
    - acc is not updated and no result is produced for this window.
  - armed=0 and state≠0: ignored, no error. Covers leaving reset mid-sequence or recovering after an error.
- prev_state<=state every edge.
- out_valid:
  - High for exactly the one cycle following the edge that sampled state==15 in a legal window.
  - Otherwise 0.
  - Back-to-back windows give one strobe every 16 cycles.
- acc_out: changes only together with out_valid=1.
- Latency: result visible 1 cycle after the state==15 sample.
- seq_err: stays 1 until rst. Accumulation resumes normally at the next state==0.
- After 15, the expected next value is 0, which is handled by the state==0 case.

Optional Feature:
- Macro: ACC_DP16_RELU_EN.
- Defined: the value stored to acc_out is ReLU(sum), i.e. 0 if the final sum is negative, else the sum. The internal acc is unaffected and out_valid timing is unchanged.
- Undefined: acc_out is the raw signed sum.

Test Plan:
- Reset then controller counts 0..15 with x_in=1, w_in=1 -> one cycle after the state==15 edge: out_valid=1, acc_out=16; out_valid=0 next cycle; seq_err=0.
- Two back-to-back windows:
  - Window 1: x=-128, w=-128 -> acc_out=262144.
  - Window 2: x=-128, w=127 -> acc_out=-260096 (0 with ACC_DP16_RELU_EN).
  - Strobes exactly 16 cycles apart.
- Alternating x=+3/-3 with w=5 across a window -> acc_out=0; then x=i, w=i for i=state -> acc_out=1240.
- rst pulsed mid-window (at state==7), then controller restarts at 0 with x=w=2 -> acc_out=64 after the next 15. No strobe from the aborted window; seq_err=0.
- Release reset while state is mid-count (e.g. 9) -> no out_valid and no seq_err until after a full 0..15 window completes.
- Force state 0,1,2,4 (skip) -> seq_err=1 from the next cycle and no out_valid for that window. A following clean window still produces a correct acc_out while seq_err stays 1 until rst.
